// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache controller slice.
package cache_pkg;

  localparam int unsigned CACHE_WIDTH   = 8;
  localparam int unsigned CACHE_WAYS    = 4;
  localparam int unsigned CACHE_TOTAL   = 16;
  localparam int unsigned CACHE_ADDR_W  = 8;
  localparam int unsigned CACHE_SETS    = CACHE_TOTAL / CACHE_WAYS;
  localparam int unsigned CACHE_INDEX_W = $clog2(CACHE_SETS);
  localparam int unsigned CACHE_TAG_W   = CACHE_ADDR_W - CACHE_INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_e;

  // Tag-store entry, sized for the package default geometry.
  typedef struct packed {
    logic                   valid;
    logic [CACHE_TAG_W-1:0] tag;
  } tag_entry_t;

  function automatic int unsigned sets_of(input int unsigned total, input int unsigned ways);
    return total / ways;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Fill-way chooser: lowest invalid way first, else the set's round-robin pointer.
module cache_victim_sel #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(SETS)-1:0]   index_i,
  input  logic [WAYS-1:0]           valid_i,
  input  logic                      fill_i,
  output logic [$clog2(WAYS)-1:0]   victim_o
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] rr_q [SETS];

  always_comb begin
    victim_o = rr_q[index_i];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WAY_W'(w);
    end
  end

  // The pointer only moves when it actually chose the victim of a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fill_i && (&valid_i)) begin
      rr_q[index_i] <= rr_q[index_i] + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate set-associative cache sequencer with tag store.
// Optional CACHE_STATS_EN adds saturating 16-bit hit/miss counters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WIDTH      = CACHE_WIDTH,
  parameter int unsigned WAYS       = CACHE_WAYS,
  parameter int unsigned TOTAL_SIZE = CACHE_TOTAL,
  parameter int unsigned ADDR_W     = CACHE_ADDR_W
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             cpu_req,
  input  logic                                             cpu_we,
  input  logic [ADDR_W-1:0]                                cpu_addr,
  input  logic [WIDTH-1:0]                                 cpu_wdata,
  output logic [WIDTH-1:0]                                 cpu_rdata,
  output logic                                             cpu_done,
  output logic                                             cpu_hit,
  output logic                                             arr_we,
  output logic [$clog2(WAYS)-1:0]                          arr_way,
  output logic [$clog2(sets_of(TOTAL_SIZE, WAYS))-1:0]     arr_index,
  output logic [WIDTH-1:0]                                 arr_wdata,
  input  logic [WIDTH-1:0]                                 arr_rdata,
  output logic                                             mem_req,
  output logic                                             mem_we,
  output logic [ADDR_W-1:0]                                mem_addr,
  output logic [WIDTH-1:0]                                 mem_wdata,
  input  logic                                             mem_ack,
  input  logic [WIDTH-1:0]                                 mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                                      hit_count,
  output logic [15:0]                                      miss_count
`endif
);

  localparam int unsigned SETS    = sets_of(TOTAL_SIZE, WAYS);
  localparam int unsigned INDEX_W = $clog2(SETS);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W;
  localparam int unsigned WAY_W   = $clog2(WAYS);

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               we_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               hit_q;
  logic [WAY_W-1:0]   hit_way_q;
  logic               cpu_done_q, cpu_hit_q;
  logic [WIDTH-1:0]   cpu_rdata_q;
  logic               mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [WIDTH-1:0]   mem_wdata_q;
  tag_entry_t         tag_store_q [SETS][WAYS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WAYS-1:0]    set_valid;
  logic               lk_hit;
  logic [WAY_W-1:0]   lk_way;
  logic [WAY_W-1:0]   victim;
  logic               fill;

  assign idx  = addr_q[INDEX_W-1:0];
  assign tag  = addr_q[ADDR_W-1:INDEX_W];
  assign fill = (state_q == MEM_RD) && mem_ack;

  // Scan high-to-low so the lowest matching way is the one that sticks.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    set_valid = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      set_valid[w] = tag_store_q[idx][w].valid;
      if (tag_store_q[idx][w].valid && (tag_store_q[idx][w].tag == tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  cache_victim_sel #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_victim_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .index_i  (idx),
    .valid_i  (set_valid),
    .fill_i   (fill),
    .victim_o (victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      cpu_done_q  <= 1'b0;
      cpu_hit_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) tag_store_q[s][w] <= '0;
      end
    end else begin
      cpu_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (we_q) begin
            hit_q       <= lk_hit;
            hit_way_q   <= lk_way;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= MEM_WR;
          end else if (lk_hit) begin
            cpu_rdata_q <= arr_rdata;
            cpu_hit_q   <= 1'b1;
            cpu_done_q  <= 1'b1;
            state_q     <= RESP;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
            state_q    <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            mem_req_q                <= 1'b0;
            tag_store_q[idx][victim] <= tag_entry_t'{valid: 1'b1, tag: tag};
            cpu_rdata_q              <= mem_rdata;
            cpu_hit_q                <= 1'b0;
            cpu_done_q               <= 1'b1;
            state_q                  <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_hit_q  <= hit_q;
            cpu_done_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array controls are combinational: fill data is only valid in the ack cycle.
  always_comb begin
    arr_we    = 1'b0;
    arr_way   = '0;
    arr_wdata = wdata_q;
    unique case (state_q)
      LOOKUP: arr_way = lk_way;
      MEM_RD: begin
        arr_way = victim;
        if (mem_ack) begin
          arr_we    = 1'b1;
          arr_wdata = mem_rdata;
        end
      end
      MEM_WR: begin
        arr_way = hit_way_q;
        arr_we  = mem_ack && hit_q;
      end
      default: arr_way = '0;
    endcase
  end

  assign arr_index = idx;
  assign cpu_done  = cpu_done_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (cpu_done_q) begin
      if (cpu_hit_q && (hit_cnt_q != 16'hFFFF))    hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!cpu_hit_q && (miss_cnt_q != 16'hFFFF))  miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
